// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_arbiter
// Purpose  : Arbitrates four write requesters onto a shared bus and issues a
//            one-cycle load strobe to one of four 16-bit register slices.
//            Round-robin by default. Defining ARB_FIXED_PRIO_EN selects fixed
//            priority instead (req[0] highest).
// Revision : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    waddr,
    input  logic [DW*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic [3:0]            ld,
    output logic [DW-1:0]         d,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_GRANT = 2'b01;
    localparam logic [1:0] S_WRITE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [3:0]       ld_q, ld_d;
    logic [DW-1:0]    d_q, d_d;
    logic [1:0]       addr_q, addr_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] req_masked;
    logic [1:0]       search_start;
    logic [1:0]       cand;
    logic             win_any;
    logic [1:0]       win_idx;

`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic [1:0]       ptr_adv;

    // Pointer position after the current grant's write completes.
    assign ptr_adv = win_q + 2'd1;
`endif

    // Pick the winning requester; the requester being acked is hidden in WRITE
    // because it has not yet had a chance to see its ack and drop req.
    always_comb begin
        req_masked = req;
        if (state_q == S_WRITE) begin
            req_masked = req & ~gnt_q;
        end
`ifdef ARB_FIXED_PRIO_EN
        search_start = 2'd0;
`else
        search_start = (state_q == S_WRITE) ? ptr_adv : ptr_q;
`endif
        win_any = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = search_start + 2'(k);
            if (!win_any && req_masked[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state logic for the IDLE / GRANT / WRITE sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = win_any ? S_GRANT : S_IDLE;
            S_GRANT: state_d = S_WRITE;
            S_WRITE: state_d = win_any ? S_GRANT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched request.
    always_comb begin
        gnt_d  = gnt_q;
        ack_d  = '0;
        ld_d   = '0;
        d_d    = d_q;
        addr_d = addr_q;
        busy_d = (state_d != S_IDLE);
`ifndef ARB_FIXED_PRIO_EN
        ptr_d  = ptr_q;
        win_d  = win_q;
`endif
        case (state_q)
            S_IDLE, S_WRITE: begin
`ifndef ARB_FIXED_PRIO_EN
                if (state_q == S_WRITE) begin
                    ptr_d = ptr_adv;
                end
`endif
                gnt_d = '0;
                if (win_any) begin
                    gnt_d[win_idx] = 1'b1;
                    d_d    = wdata[int'(win_idx)*DW +: DW];
                    addr_d = waddr[int'(win_idx)*2 +: 2];
`ifndef ARB_FIXED_PRIO_EN
                    win_d  = win_idx;
`endif
                end
            end
            S_GRANT: begin
                ld_d[addr_q] = 1'b1;
                ack_d        = gnt_q;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset kills any in-flight write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            ld_q    <= '0;
            d_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
            win_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ld_q    <= ld_d;
            d_q     <= d_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
            win_q   <= win_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign ld   = ld_q;
    assign d    = d_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_write_arbiter
// Purpose  : Directed, table-driven bench for regbank_write_arbiter
//            (default round-robin build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  ld;
    logic [15:0] d;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  waddr;
        logic [63:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [3:0]  ld;
        logic [15:0] d;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    regbank_write_arbiter #(.N_REQ(4), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .waddr (waddr),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .ld    (ld),
        .d     (d),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                           input logic [3:0] e_ld, input logic [15:0] e_d, input logic e_busy);
        chk({tag, ".gnt"},  64'(gnt),  64'(e_gnt));
        chk({tag, ".ack"},  64'(ack),  64'(e_ack));
        chk({tag, ".ld"},   64'(ld),   64'(e_ld));
        chk({tag, ".d"},    64'(d),    64'(e_d));
        chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    endtask

    task automatic add(input logic [3:0] r, input logic [7:0] wa, input logic [63:0] wd,
                       input logic [3:0] g, input logic [3:0] a, input logic [3:0] l,
                       input logic [15:0] dd, input logic b);
        vq.push_back('{r, wa, wd, g, a, l, dd, b});
    endtask

    // Drive inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic [3:0] r, input logic [7:0] wa, input logic [63:0] wd);
        @(negedge clk);
        req   = r;
        waddr = wa;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0]  WA_ALL = 8'hE4;
    localparam logic [63:0] WD_ALL = 64'h4444_3333_2222_1111;
    localparam logic [7:0]  WA_ONE = 8'h30;
    localparam logic [63:0] WD_ONE = 64'h0000_BEEF_0000_0000;
    localparam logic [7:0]  WA_R1  = 8'h04;
    localparam logic [63:0] WD_R1  = 64'h0000_0000_1234_0000;
    localparam logic [63:0] WD_DRP = 64'h0000_CAFE_0000_0000;
    localparam logic [7:0]  WA_SAM = 8'h82;
    localparam logic [63:0] WD_SAM = 64'h5555_0000_0000_AAAA;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        req    = '0;
        waddr  = '0;
        wdata  = '0;

        // All four requesting continuously: grants 0,1,2,3,0, a load every 2 cycles.
        add(4'b1111, WA_ALL, WD_ALL, 4'b0001, 4'b0000, 4'b0000, 16'h1111, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0001, 4'b0001, 4'b0001, 16'h1111, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0010, 4'b0000, 4'b0000, 16'h2222, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0010, 4'b0010, 4'b0010, 16'h2222, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0100, 4'b0000, 4'b0000, 16'h3333, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0100, 4'b0100, 4'b0100, 16'h3333, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b1000, 4'b0000, 4'b0000, 16'h4444, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b1000, 4'b1000, 4'b1000, 16'h4444, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0001, 4'b0000, 4'b0000, 16'h1111, 1'b1);
        add(4'b1111, WA_ALL, WD_ALL, 4'b0001, 4'b0001, 4'b0001, 16'h1111, 1'b1);
        add(4'b0000, WA_ALL, WD_ALL, 4'b0000, 4'b0000, 4'b0000, 16'h1111, 1'b0);
        // Single request from requester 2 to register 3.
        add(4'b0100, WA_ONE, WD_ONE, 4'b0100, 4'b0000, 4'b0000, 16'hBEEF, 1'b1);
        add(4'b0100, WA_ONE, WD_ONE, 4'b0100, 4'b0100, 4'b1000, 16'hBEEF, 1'b1);
        add(4'b0000, WA_ONE, WD_ONE, 4'b0000, 4'b0000, 4'b0000, 16'hBEEF, 1'b0);
        // Requester 1 holds req through its ack: one IDLE cycle, then re-grant.
        add(4'b0010, WA_R1,  WD_R1,  4'b0010, 4'b0000, 4'b0000, 16'h1234, 1'b1);
        add(4'b0010, WA_R1,  WD_R1,  4'b0010, 4'b0010, 4'b0010, 16'h1234, 1'b1);
        add(4'b0010, WA_R1,  WD_R1,  4'b0000, 4'b0000, 4'b0000, 16'h1234, 1'b0);
        add(4'b0010, WA_R1,  WD_R1,  4'b0010, 4'b0000, 4'b0000, 16'h1234, 1'b1);
        add(4'b0010, WA_R1,  WD_R1,  4'b0010, 4'b0010, 4'b0010, 16'h1234, 1'b1);
        add(4'b0000, WA_R1,  WD_R1,  4'b0000, 4'b0000, 4'b0000, 16'h1234, 1'b0);
        // Requester 2 drops req during GRANT; the latched write still happens.
        add(4'b0100, 8'h00,  WD_DRP, 4'b0100, 4'b0000, 4'b0000, 16'hCAFE, 1'b1);
        add(4'b0000, 8'h00,  WD_DRP, 4'b0100, 4'b0100, 4'b0001, 16'hCAFE, 1'b1);
        add(4'b0000, 8'h00,  WD_DRP, 4'b0000, 4'b0000, 4'b0000, 16'hCAFE, 1'b0);

        // Reset state.
        #1 reset = 1'b1;
        #1 chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].req, vq[i].waddr, vq[i].wdata);
            chk_all($sformatf("vec%0d", i), vq[i].gnt, vq[i].ack, vq[i].ld, vq[i].d, vq[i].busy);
        end

        // Asynchronous reset in the middle of WRITE.
        step(4'b1000, 8'h40, 64'h7777_0000_0000_0000);
        chk_all("rst_grant", 4'b1000, 4'b0000, 4'b0000, 16'h7777, 1'b1);
        step(4'b1000, 8'h40, 64'h7777_0000_0000_0000);
        chk_all("rst_write", 4'b1000, 4'b1000, 4'b0010, 16'h7777, 1'b1);
        #2 reset = 1'b1;
        #1 chk_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Requesters 0 and 3 both write register 2; pointer restarted at 0.
        step(4'b1001, WA_SAM, WD_SAM);
        chk_all("same_g0", 4'b0001, 4'b0000, 4'b0000, 16'hAAAA, 1'b1);
        step(4'b1001, WA_SAM, WD_SAM);
        chk_all("same_w0", 4'b0001, 4'b0001, 4'b0100, 16'hAAAA, 1'b1);
        step(4'b1000, WA_SAM, WD_SAM);
        chk_all("same_g3", 4'b1000, 4'b0000, 4'b0000, 16'h5555, 1'b1);
        step(4'b1000, WA_SAM, WD_SAM);
        chk_all("same_w3", 4'b1000, 4'b1000, 4'b0100, 16'h5555, 1'b1);
        step(4'b0000, WA_SAM, WD_SAM);
        chk_all("same_end", 4'b0000, 4'b0000, 4'b0000, 16'h5555, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
